uart_tx_engine: RTL and testbench

//   Serial UART transmitter; pairs with the receive side that uart_monitor observes.

---
 rtl/uart_tx_engine.sv | 124 ++++++++++++
 tb/tb_uart_tx_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter with valid/ready input, built-in baud divider and registered tx pin.
module uart_tx_engine #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap;
  assign wrap     = cnt_q == CW'(CPB - 1);
  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? cnt_q : (wrap ? '0 : cnt_q + 1'b1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (tx_valid && ready_q) begin
        sh_d    = tx_data;
        par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
        tx_d    = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: if (wrap) begin
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
        state_d = DATA;
      end
      DATA: if (wrap) begin
        if (idx_q == 3'(DATA_BITS - 1)) begin
          idx_d   = '0;
          tx_d    = (PARITY != 0) ? par_q : 1'b1;
          state_d = (PARITY != 0) ? PAR : STOP;
        end else begin
          idx_d = idx_q + 1'b1;
          tx_d  = sh_q[0];
          sh_d  = sh_q >> 1;
        end
      end
      PAR: if (wrap) begin
        tx_d    = 1'b1;
        idx_d   = '0;
        state_d = STOP;
      end
      STOP: if (wrap) begin
        if (idx_q == 3'(STOP_BITS - 1)) begin
          idx_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: three engines (8N1, 8E2, 8O2) at CPB=10 checked by a frame-decoding scoreboard.
module tb_uart_tx_engine;
  localparam int CPB = 10;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d [3];
  logic [2:0] v = 3'b000;
  logic [2:0] rdy, txl, busy, done;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] q0 [$], q1 [$], q2 [$];
  logic [2:0]  act = 3'b000;
  int          t [3], werr [3], cerr [3], last_start [3], prev_start [3];
  logic [11:0] eb [3], gb [3];
  logic [7:0]  eby [3];

  uart_tx_engine #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]), .tx(txl[0]), .busy(busy[0]), .tx_done(done[0]));
  uart_tx_engine #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]), .tx(txl[1]), .busy(busy[1]), .tx_done(done[1]));
  uart_tx_engine #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]), .tx(txl[2]), .busy(busy[2]), .tx_done(done[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int par_mode(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 1;
  endfunction

  function automatic int nbits(input int i);
    return 9 + (par_mode(i) != 0 ? 1 : 0) + (i == 0 ? 1 : 2);
  endfunction

  function automatic logic [11:0] frame(input int i, input logic [7:0] b);
    logic [11:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int k = 0; k < nbits(i); k++) f[k] = 1'b1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      f[k+1] = b[k];
      ones += int'(b[k]);
    end
    if (par_mode(i) == 2) f[9] = (ones % 2) == 1;
    if (par_mode(i) == 1) f[9] = (ones % 2) == 0;
    return f;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
  endfunction

  function automatic logic [7:0] qpop(input int i);
    return (i == 0) ? q0.pop_front() : (i == 1) ? q1.pop_front() : q2.pop_front();
  endfunction

  task automatic qpush(input int i, input logic [7:0] b);
    if (i == 0) q0.push_back(b);
    else if (i == 1) q1.push_back(b);
    else q2.push_back(b);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) act[i] = 1'b0;
      else begin
        if (act[i] && t[i] == nbits(i) * CPB + 1) begin
          check("done_clear", 32'(done[i]), 0);
          act[i] = 1'b0;
        end
        if (!act[i] && txl[i] == 1'b0) begin
          act[i] = 1'b1;
          t[i] = 0;
          werr[i] = 0;
          cerr[i] = 0;
          gb[i] = '0;
          prev_start[i] = last_start[i];
          last_start[i] = cyc;
          if (qsize(i) == 0) begin
            check("unexpected_frame", 1, 0);
            eby[i] = '0;
          end else eby[i] = qpop(i);
          eb[i] = frame(i, eby[i]);
        end
        if (act[i]) begin
          if (t[i] < nbits(i) * CPB) begin
            if (txl[i] !== eb[i][t[i] / CPB]) werr[i]++;
            if (done[i] || !busy[i] || rdy[i]) cerr[i]++;
            if (t[i] % CPB == CPB / 2) gb[i][t[i] / CPB] = txl[i];
          end else begin
            check("frame_bits", 32'(gb[i]), 32'(eb[i]));
            check("rx_byte", 32'(gb[i][8:1]), 32'(eby[i]));
            check("wave_errs", werr[i], 0);
            check("ctl_errs", cerr[i], 0);
            check("done_at_end", 32'(done[i]), 1);
            check("ready_at_end", 32'(rdy[i]), 1);
            check("busy_at_end", 32'(busy[i]), 0);
            check("tx_idle_at_end", 32'(txl[i]), 1);
          end
          t[i]++;
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    d[i] = b;
    v[i] = 1'b1;
    while (!rdy[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("send_timeout", 0, 1);
      v[i] = 1'b0;
    end else begin
      qpush(i, b);
      @(negedge clk);
      if (!hold) v[i] = 1'b0;
      d[i] = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((act != 3'b000 || rdy != 3'b111) && n < 5000);
    if (n >= 5000) check("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) d[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {20'd0, txl, rdy, busy, done}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'h55, 0);
    wait_idle();
    fork
      send(1, 8'hA3, 0);
      send(2, 8'hA3, 0);
    join
    wait_idle();
    send(0, 8'h00, 1);
    send(0, 8'hFF, 0);
    wait_idle();
    check("b2b_period", last_start[0] - prev_start[0], 101);
    send(0, 8'h00, 0);
    repeat (45) @(posedge clk);
    #3;
    check("pre_abort_tx", 32'(txl[0]), 0);
    rst_n = 1'b0;
    #1;
    check("async_abort", {29'd0, txl[0], rdy[0], busy[0]}, 32'b110);
    check("async_done", 32'(done[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume", {26'd0, txl, rdy}, {26'd0, 3'b111, 3'b111});
    send(0, 8'h3C, 0);
    wait_idle();
    fork
      for (int k = 0; k < 20; k++) send(0, 8'($urandom), 0);
      for (int k = 0; k < 20; k++) send(1, 8'($urandom), 0);
      for (int k = 0; k < 20; k++) send(2, 8'($urandom), 0);
    join
    wait_idle();
    check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
